// File: rtl/streamer_tcdm_rr_arbiter.sv
// Shares one TCDM master port among NCH streamer channels: round-robin arbitration with
// locking until grant, and in-order read-response routing through an outstanding-ID FIFO.
module streamer_tcdm_rr_arbiter #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            enable_i,
    input  logic [NCH-1:0]                  ch_req_i,
    output logic [NCH-1:0]                  ch_gnt_o,
    input  logic [NCH*ADDR_WIDTH-1:0]       ch_add_i,
    input  logic [NCH-1:0]                  ch_wen_i,
    input  logic [NCH*DATA_WIDTH/8-1:0]     ch_be_i,
    input  logic [NCH*DATA_WIDTH-1:0]       ch_data_i,
    output logic [DATA_WIDTH-1:0]           ch_r_data_o,
    output logic [NCH-1:0]                  ch_r_valid_o,
    output logic                            tcdm_req_o,
    input  logic                            tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]           tcdm_add_o,
    output logic                            tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0]         tcdm_be_o,
    output logic [DATA_WIDTH-1:0]           tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]           tcdm_r_data_i,
    input  logic                            tcdm_r_valid_i,
    output logic [$clog2(MAX_OUTST):0]      outst_o,
    output logic                            err_o
);

    localparam int unsigned IdxW = $clog2(NCH);
    localparam int unsigned PtrW = $clog2(MAX_OUTST);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTST);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q;
    logic [IdxW-1:0] lock_id_q;
    logic [IdxW-1:0] id_mem_q [MAX_OUTST];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q;

    logic [NCH-1:0]  eligible;
    logic            win_valid;
    logic [IdxW-1:0] winner;
    logic            gnt, push, pop;

    // Reads are held off on the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            eligible[k] = ch_req_i[k] & (~ch_wen_i[k] | (cnt_q < MaxCnt));
        end
    end

    always_comb begin
        int unsigned     idx;
        logic [IdxW-1:0] idx_w;
        win_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        idx_w     = '0;
        if (lock_q) begin
            win_valid = 1'b1;
            winner    = lock_id_q;
        end else if (enable_i) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                idx   = (32'(rr_ptr_q) + i) % NCH;
                idx_w = IdxW'(idx);
                if (!win_valid && eligible[idx_w]) begin
                    win_valid = 1'b1;
                    winner    = idx_w;
                end
            end
        end
    end

    always_comb begin
        tcdm_req_o  = win_valid;
        tcdm_add_o  = '0;
        tcdm_wen_o  = 1'b0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        ch_gnt_o    = '0;
        if (win_valid) begin
            tcdm_add_o       = ch_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            tcdm_wen_o       = ch_wen_i[winner];
            tcdm_be_o        = ch_be_i[winner*BeW +: BeW];
            tcdm_data_o      = ch_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
            ch_gnt_o[winner] = tcdm_gnt_i;
        end
    end

    assign gnt  = win_valid & tcdm_gnt_i;
    assign push = gnt & tcdm_wen_o;
    assign pop  = tcdm_r_valid_i & (cnt_q != '0);

    always_comb begin
        ch_r_valid_o = '0;
        if (pop) begin
            ch_r_valid_o[id_mem_q[rd_ptr_q]] = 1'b1;
        end
    end

    assign ch_r_data_o = tcdm_r_data_i;
    assign rr_ptr_d    = (winner == LastIdx) ? '0 : winner + 1'b1;
    assign cnt_d       = cnt_q + CntW'(push) - CntW'(pop);
    assign outst_o     = cnt_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) id_mem_q[i] <= '0;
        end else if (clear_i) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) id_mem_q[i] <= '0;
        end else begin
            if (gnt) begin
                rr_ptr_q <= rr_ptr_d;
                lock_q   <= 1'b0;
            end else if (win_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= winner;
            end
            if (push) begin
                id_mem_q[wr_ptr_q] <= winner;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            // Response with nothing outstanding is dropped and flagged until reset/clear.
            if (tcdm_r_valid_i && cnt_q == '0) err_q <= 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_streamer_tcdm_rr_arbiter.sv
// Randomized bench for streamer_tcdm_rr_arbiter against a queue-based reference model of the
// arbitration and response-routing rules.
module tb_streamer_tcdm_rr_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MO  = 4;
    localparam int CW  = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              enable_i = 1'b0;
    logic [NCH-1:0]    ch_req_i = '0;
    logic [NCH-1:0]    ch_gnt_o;
    logic [NCH*AW-1:0] ch_add_i = '0;
    logic [NCH-1:0]    ch_wen_i = '0;
    logic [NCH*DW/8-1:0] ch_be_i = '0;
    logic [NCH*DW-1:0] ch_data_i = '0;
    logic [DW-1:0]     ch_r_data_o;
    logic [NCH-1:0]    ch_r_valid_o;
    logic              tcdm_req_o;
    logic              tcdm_gnt_i = 1'b0;
    logic [AW-1:0]     tcdm_add_o;
    logic              tcdm_wen_o;
    logic [DW/8-1:0]   tcdm_be_o;
    logic [DW-1:0]     tcdm_data_o;
    logic [DW-1:0]     tcdm_r_data_i = '0;
    logic              tcdm_r_valid_i = 1'b0;
    logic [CW-1:0]     outst_o;
    logic              err_o;

    streamer_tcdm_rr_arbiter #(
        .NCH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .ch_req_i(ch_req_i), .ch_gnt_o(ch_gnt_o), .ch_add_i(ch_add_i), .ch_wen_i(ch_wen_i),
        .ch_be_i(ch_be_i), .ch_data_i(ch_data_i), .ch_r_data_o(ch_r_data_o),
        .ch_r_valid_o(ch_r_valid_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
        .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
        .tcdm_data_o(tcdm_data_o), .tcdm_r_data_i(tcdm_r_data_i),
        .tcdm_r_valid_i(tcdm_r_valid_i), .outst_o(outst_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int  m_ptr;
    bit  m_lock;
    int  m_lock_id;
    int  m_q[$];
    bit  m_err;

    // Per-channel pending requests, held until granted
    bit          pend[NCH];
    logic [AW-1:0] c_add[NCH];
    bit          c_wen[NCH];
    logic [3:0]  c_be[NCH];
    logic [DW-1:0] c_data[NCH];

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_lock_id = 0; m_err = 0;
        m_q.delete();
    endtask

    task automatic apply_ch();
        for (int k = 0; k < NCH; k++) begin
            ch_req_i[k]            = pend[k];
            ch_wen_i[k]            = c_wen[k];
            ch_add_i[k*AW +: AW]   = c_add[k];
            ch_be_i[k*4 +: 4]      = c_be[k];
            ch_data_i[k*DW +: DW]  = c_data[k];
        end
    endtask

    task automatic model_eval(output bit valid, output int win);
        int idx;
        valid = 0;
        win   = 0;
        if (m_lock) begin
            valid = 1;
            win   = m_lock_id;
        end else if (enable_i) begin
            for (int i = 0; i < NCH; i++) begin
                idx = (m_ptr + i) % NCH;
                if (!valid && pend[idx] && (!c_wen[idx] || m_q.size() < MO)) begin
                    valid = 1;
                    win   = idx;
                end
            end
        end
    endtask

    task automatic check_outputs(input bit valid, input int win);
        logic [NCH-1:0] exp_gnt;
        logic [NCH-1:0] exp_rv;
        exp_gnt = '0;
        exp_rv  = '0;
        if (valid && tcdm_gnt_i) exp_gnt[win] = 1'b1;
        if (tcdm_r_valid_i && m_q.size() > 0) exp_rv[m_q[0]] = 1'b1;
        check("tcdm_req", 64'(tcdm_req_o), 64'(valid));
        check("ch_gnt", 64'(ch_gnt_o), 64'(exp_gnt));
        check("ch_r_valid", 64'(ch_r_valid_o), 64'(exp_rv));
        check("outst", 64'(outst_o), 64'(m_q.size()));
        check("err", 64'(err_o), 64'(m_err));
        if (valid) begin
            check("tcdm_add", 64'(tcdm_add_o), 64'(c_add[win]));
            check("tcdm_wen", 64'(tcdm_wen_o), 64'(c_wen[win]));
            check("tcdm_be", 64'(tcdm_be_o), 64'(c_be[win]));
            check("tcdm_data", 64'(tcdm_data_o), 64'(c_data[win]));
        end
        if (exp_rv != '0) check("r_data", 64'(ch_r_data_o), 64'(tcdm_r_data_i));
    endtask

    task automatic model_update(input bit valid, input int win);
        bit granted;
        granted = valid && tcdm_gnt_i;
        if (granted) pend[win] = 0;
        if (clear_i) begin
            model_reset();
        end else begin
            if (tcdm_r_valid_i) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1;
            end
            if (granted) begin
                m_ptr  = (win + 1) % NCH;
                m_lock = 0;
                if (c_wen[win]) m_q.push_back(win);
            end else if (valid) begin
                m_lock    = 1;
                m_lock_id = win;
            end
        end
    endtask

    bit valid;
    int win;

    initial begin
        model_reset();
        for (int k = 0; k < NCH; k++) begin
            pend[k] = 0; c_add[k] = '0; c_wen[k] = 0; c_be[k] = '0; c_data[k] = '0;
        end
        apply_ch();
        #12;
        model_eval(valid, win);
        check_outputs(valid, win);
        check("reset_outst", 64'(outst_o), 64'd0);
        check("reset_req", 64'(tcdm_req_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            for (int k = 0; k < NCH; k++) begin
                if (!pend[k] && ($urandom % 2 == 0)) begin
                    pend[k]   = 1;
                    c_add[k]  = $urandom;
                    c_wen[k]  = ($urandom % 3 != 0);
                    c_be[k]   = 4'($urandom);
                    c_data[k] = $urandom;
                end
            end
            apply_ch();
            enable_i       = ($urandom % 5 != 0);
            tcdm_gnt_i     = ($urandom % 5 < 3);
            tcdm_r_valid_i = (m_q.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 60 == 0);
            tcdm_r_data_i  = $urandom;
            clear_i        = ($urandom % 120 == 0);
            #1;
            model_eval(valid, win);
            check_outputs(valid, win);
            @(posedge clk_i);
            model_update(valid, win);
        end

        // Asynchronous reset mid-cycle, with requests still pending
        @(negedge clk_i);
        clear_i = 1'b0;
        tcdm_r_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        model_eval(valid, win);
        check_outputs(valid, win);
        check("async_rst_outst", 64'(outst_o), 64'd0);
        check("async_rst_err", 64'(err_o), 64'd0);
        for (int k = 0; k < NCH; k++) pend[k] = 0;
        apply_ch();
        #1;
        check("async_rst_req", 64'(tcdm_req_o), 64'd0);
        check("async_rst_gnt", 64'(ch_gnt_o), 64'd0);
        check("async_rst_rv", 64'(ch_r_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
